// File: rtl/ldpc_iter_scheduler_pkg.sv
// Shared definitions for the LDPC iteration scheduler: FSM encoding, reset
// values and default iteration/watchdog limits.
package ldpc_iter_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_N_ITER  = 5;
    localparam int DEF_TIMEOUT = 64;

    // in_ready is the only output that comes out of reset high.
    localparam logic RST_IN_READY = 1'b1;
    localparam logic RST_LOW      = 1'b0;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ldpc_iter_scheduler_iter_watchdog.sv
// Per-iteration watchdog: loadable up-counter that stops at TIMEOUT-1 and
// raises a terminal-count flag there.
module iter_watchdog
    import ldpc_iter_scheduler_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    assign o_tc = (r_count == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ldpc_iter_scheduler.sv
// Iteration scheduler for the min-sum decoder: feeds each layer result back
// as the next iteration's input until N_ITER, early stop or watchdog expiry.
module ldpc_iter_scheduler
    import ldpc_iter_scheduler_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N_V     = 44,
    parameter int E       = 147,
    parameter int N_ITER  = DEF_N_ITER,
    parameter int ITER_W  = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH*N_V-1:0] in_llrs,
    output logic                 layer_data_ready,
    output logic                 layer_prev_ready,
    output logic [WIDTH*N_V-1:0] layer_all_llrs,
    output logic [WIDTH*E-1:0]   layer_prev_proc_elem,
    input  logic [WIDTH*E-1:0]   layer_proc_elem,
    input  logic                 layer_interm_ready,
    input  logic                 early_stop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH*E-1:0]   out_proc_elem,
    output logic [WIDTH*N_V-1:0] out_llrs,
    output logic [ITER_W-1:0]    out_iters,
    output logic                 out_early,
    output logic                 out_timeout
);

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_data_ready;
    logic                 r_prev_ready;
    logic                 r_out_valid;
    logic                 r_early;
    logic                 r_timeout;
    logic [ITER_W-1:0]    r_iter;
    logic [WIDTH*N_V-1:0] r_llrs;
    logic [WIDTH*E-1:0]   r_fb;

    logic                 w_wd_load;
    logic                 w_wd_en;
    logic                 w_wd_tc;
    logic [ITER_W-1:0]    w_iter_inc;

    assign w_wd_load  = (r_state == S_START);
    assign w_wd_en    = (r_state == S_WAIT);
    assign w_iter_inc = r_iter + ITER_W'(1);

    iter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_wd_load),
        .i_en   (w_wd_en),
        .o_tc   (w_wd_tc)
    );

    // NOTE: the wide LLR and feedback registers are reset too, so a frame
    // aborted by rst leaves nothing stale visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_ready   <= RST_IN_READY;
            r_data_ready <= RST_LOW;
            r_prev_ready <= RST_LOW;
            r_out_valid  <= RST_LOW;
            r_early      <= RST_LOW;
            r_timeout    <= RST_LOW;
            r_iter       <= '0;
            r_llrs       <= '0;
            r_fb         <= '0;
        end else begin
            r_prev_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_llrs       <= in_llrs;
                        r_fb         <= '0;
                        r_iter       <= '0;
                        r_early      <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_in_ready   <= 1'b0;
                        r_data_ready <= 1'b1;
                        r_prev_ready <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A layer result arriving on the watchdog's last cycle still counts.
                    if (layer_interm_ready) begin
                        r_fb   <= layer_proc_elem;
                        r_iter <= w_iter_inc;
                        if (early_stop || (w_iter_inc == ITER_W'(N_ITER))) begin
                            r_early      <= early_stop;
                            r_data_ready <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_prev_ready <= 1'b1;
                            r_state      <= S_START;
                        end
                    end else if (w_wd_tc) begin
                        r_timeout    <= 1'b1;
                        r_data_ready <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready             = r_in_ready;
    assign layer_data_ready     = r_data_ready;
    assign layer_prev_ready     = r_prev_ready;
    assign layer_all_llrs       = r_llrs;
    assign layer_prev_proc_elem = r_fb;
    assign out_valid            = r_out_valid;
    assign out_proc_elem        = r_fb;
    assign out_llrs             = r_llrs;
    assign out_iters            = r_iter;
    assign out_early            = r_early;
    assign out_timeout          = r_timeout;

endmodule

// File: tb/tb_ldpc_iter_scheduler.sv
// Self-checking bench for ldpc_iter_scheduler: behavioural layer model plus a
// scoreboard of expected frame results popped when out_valid appears.
module tb_ldpc_iter_scheduler;

    localparam int WIDTH   = 8;
    localparam int N_V     = 44;
    localparam int E       = 147;
    localparam int N_ITER  = 5;
    localparam int ITER_W  = 4;
    localparam int TIMEOUT = 64;
    localparam int LW      = WIDTH * N_V;
    localparam int EW      = WIDTH * E;
    localparam int LOG_N   = 128;

    typedef struct {
        logic [EW-1:0] proc;
        logic [LW-1:0] llrs;
        int            iters;
        bit            early;
        bit            tmo;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [LW-1:0]     in_llrs;
    logic              layer_data_ready;
    logic              layer_prev_ready;
    logic [LW-1:0]     layer_all_llrs;
    logic [EW-1:0]     layer_prev_proc_elem;
    logic [EW-1:0]     layer_proc_elem;
    logic              layer_interm_ready;
    logic              early_stop;
    logic              out_valid;
    logic              out_ready;
    logic [EW-1:0]     out_proc_elem;
    logic [LW-1:0]     out_llrs;
    logic [ITER_W-1:0] out_iters;
    logic              out_early;
    logic              out_timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Layer model configuration, written only by the main sequence.
    int m_lat      = 3;
    bit m_on       = 1'b1;
    int m_early_at = 0;

    // Layer model observations, written only by the model.
    int            n_starts = 0;
    logic [EW-1:0] fb_obs [LOG_N];

    ldpc_iter_scheduler #(
        .WIDTH   (WIDTH),
        .N_V     (N_V),
        .E       (E),
        .N_ITER  (N_ITER),
        .ITER_W  (ITER_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_llrs              (in_llrs),
        .layer_data_ready     (layer_data_ready),
        .layer_prev_ready     (layer_prev_ready),
        .layer_all_llrs       (layer_all_llrs),
        .layer_prev_proc_elem (layer_prev_proc_elem),
        .layer_proc_elem      (layer_proc_elem),
        .layer_interm_ready   (layer_interm_ready),
        .early_stop           (early_stop),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_proc_elem        (out_proc_elem),
        .out_llrs             (out_llrs),
        .out_iters            (out_iters),
        .out_early            (out_early),
        .out_timeout          (out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] gen_llrs(input int f);
        logic [LW-1:0] r;
        for (int i = 0; i < N_V; i++) r[i*WIDTH +: WIDTH] = 8'(f + 13 * i);
        return r;
    endfunction

    function automatic logic [EW-1:0] gen_result(input int f, input int it);
        logic [EW-1:0] r;
        for (int i = 0; i < E; i++) r[i*WIDTH +: WIDTH] = 8'(f * 37 + it * 11 + i * 3 + 1);
        return r;
    endfunction

    // Index of the first differing edge message, for compact failure lines.
    function automatic int first_diff(input logic [EW-1:0] a, input logic [EW-1:0] b);
        for (int i = 0; i < E; i++) if (a[i*WIDTH +: WIDTH] !== b[i*WIDTH +: WIDTH]) return i;
        return -1;
    endfunction

    // Layer model: answers each start pulse after m_lat cycles, driven on negedge.
    initial begin : layer_model
        int pend;
        int it;
        int fid;
        bit prev_dr;
        pend = 0; it = 0; fid = 0; prev_dr = 1'b0;
        layer_interm_ready = 1'b0;
        early_stop         = 1'b0;
        layer_proc_elem    = '0;
        forever begin
            @(negedge clk);
            layer_interm_ready = 1'b0;
            early_stop         = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    layer_interm_ready = 1'b1;
                    layer_proc_elem    = gen_result(fid, it);
                    early_stop         = (it == m_early_at);
                end
            end
            if (layer_prev_ready) begin
                if (!prev_dr) it = 0;
                it++;
                fid = int'(layer_all_llrs[WIDTH-1:0]);
                if (n_starts < LOG_N) fb_obs[n_starts] = layer_prev_proc_elem;
                n_starts++;
                if (m_on) pend = m_lat;
            end
            prev_dr = layer_data_ready;
        end
    end

    initial begin : global_guard
        #200000;
        $display("FAIL global_timeout: bench did not finish within 200000 ns");
        $fatal(1, "bench timeout");
    end

    task automatic push_exp(input int f, input int iters, input bit early, input bit tmo);
        exp_t e;
        e.proc  = (iters == 0) ? '0 : gen_result(f, iters);
        e.llrs  = gen_llrs(f);
        e.iters = iters;
        e.early = early;
        e.tmo   = tmo;
        sb.push_back(e);
    endtask

    // Offer frame f; returns at the START cycle (one cycle after the accepting edge).
    task automatic send_frame(input int f, input int iters, input bit early, input bit tmo,
                              input bit keep_valid);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_llrs  = gen_llrs(f);
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!keep_valid) in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_f%0d: in_ready never seen within %0d cycles", f, n);
        end else begin
            push_exp(f, iters, early, tmo);
        end
        n_checks++;
        if (layer_prev_ready !== 1'b1 || layer_data_ready !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency_f%0d: prev_ready=%b data_ready=%b in_ready=%b, need 1 1 0",
                     f, layer_prev_ready, layer_data_ready, in_ready);
        end
        n_checks++;
        if (layer_all_llrs !== gen_llrs(f)) begin
            n_fail++;
            $display("FAIL layer_llrs_f%0d: got %h need %h", f, layer_all_llrs, gen_llrs(f));
        end
    endtask

    // Wait for out_valid, check its latency, pop the scoreboard and compare fields.
    task automatic wait_output(input int exp_edges, output exp_t e);
        int n;
        n = 0;
        e.proc = '0; e.llrs = '0; e.iters = 0; e.early = 1'b0; e.tmo = 1'b0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL out_valid_wait: out_valid=0 after %0d cycles, need 1", n);
        end else begin
            n_checks++;
            if (n != exp_edges) begin
                n_fail++;
                $display("FAIL done_latency: out_valid after %0d cycles, need %0d", n, exp_edges);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: out_valid with %0d expected entries, need 1", sb.size());
            end else begin
                e = sb.pop_front();
                if (out_proc_elem !== e.proc) begin
                    n_fail++;
                    $display("FAIL out_proc_elem: edge %0d got %h need %h", first_diff(out_proc_elem, e.proc),
                             out_proc_elem[first_diff(out_proc_elem, e.proc)*WIDTH +: WIDTH],
                             e.proc[first_diff(out_proc_elem, e.proc)*WIDTH +: WIDTH]);
                end
                n_checks++;
                if (out_llrs !== e.llrs) begin
                    n_fail++;
                    $display("FAIL out_llrs: got %h need %h", out_llrs, e.llrs);
                end
                n_checks++;
                if (out_iters !== ITER_W'(e.iters) || out_early !== e.early || out_timeout !== e.tmo) begin
                    n_fail++;
                    $display("FAIL out_status: iters=%0d early=%b timeout=%b, need %0d %b %b",
                             out_iters, out_early, out_timeout, e.iters, e.early, e.tmo);
                end
                n_checks++;
                if (in_ready !== 1'b0 || layer_data_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_flags: in_ready=%b data_ready=%b, need 0 0", in_ready, layer_data_ready);
                end
            end
        end
    endtask

    // Complete the output handshake (out_ready must be 1) and check the return to IDLE.
    task automatic consume_output();
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || layer_prev_ready !== 1'b0 || layer_data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b prev=%b data=%b, need 1 0 0 0",
                     in_ready, out_valid, layer_prev_ready, layer_data_ready);
        end
        n_checks++;
        if (out_iters !== '0 || out_early !== 1'b0 || out_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: iters=%0d early=%b timeout=%b, need 0 0 0", out_iters, out_early, out_timeout);
        end
        n_checks++;
        if (out_proc_elem !== '0 || out_llrs !== '0) begin
            n_fail++;
            $display("FAIL reset_data: proc_nonzero=%b llrs_nonzero=%b, need 0 0", |out_proc_elem, |out_llrs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || layer_prev_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: in_ready=%b prev=%b, need 1 0", in_ready, layer_prev_ready);
        end
    endtask

    task automatic test_full_iters();
        exp_t e;
        int   s0;
        m_lat = 3; m_early_at = 0; m_on = 1'b1;
        s0 = n_starts;
        send_frame(1, N_ITER, 1'b0, 1'b0, 1'b0);
        wait_output(N_ITER * (1 + 3), e);
        consume_output();
        n_checks++;
        if (n_starts - s0 != N_ITER) begin
            n_fail++;
            $display("FAIL full_start_count: %0d start pulses, need %0d", n_starts - s0, N_ITER);
        end
        for (int j = 0; j < N_ITER; j++) begin
            logic [EW-1:0] want;
            want = (j == 0) ? '0 : gen_result(1, j);
            n_checks++;
            if (fb_obs[s0 + j] !== want) begin
                n_fail++;
                $display("FAIL full_feedback_it%0d: edge %0d got %h need %h", j + 1, first_diff(fb_obs[s0 + j], want),
                         fb_obs[s0 + j][first_diff(fb_obs[s0 + j], want)*WIDTH +: WIDTH],
                         want[first_diff(fb_obs[s0 + j], want)*WIDTH +: WIDTH]);
            end
        end
    endtask

    task automatic test_early_stop();
        exp_t e;
        int   s0;
        m_lat = 3; m_early_at = 2; m_on = 1'b1;
        s0 = n_starts;
        send_frame(5, 2, 1'b1, 1'b0, 1'b0);
        wait_output(2 * (1 + 3), e);
        consume_output();
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (n_starts - s0 != 2) begin
            n_fail++;
            $display("FAIL early_start_count: %0d start pulses, need 2", n_starts - s0);
        end
        m_early_at = 0;
    endtask

    task automatic test_timeout();
        exp_t e;
        m_on = 1'b0;
        send_frame(3, 0, 1'b0, 1'b1, 1'b0);
        wait_output(TIMEOUT + 1, e);
        consume_output();
        m_on = 1'b1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        m_lat = 2; m_early_at = 0; m_on = 1'b1;
        out_ready = 1'b0;
        send_frame(11, N_ITER, 1'b0, 1'b0, 1'b0);
        wait_output(N_ITER * (1 + 2), e);
        in_llrs  = gen_llrs(20);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || layer_prev_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_flags_c%0d: out_valid=%b in_ready=%b prev=%b, need 1 0 0",
                         c, out_valid, in_ready, layer_prev_ready);
            end
            n_checks++;
            if (out_proc_elem !== e.proc || out_llrs !== e.llrs || out_iters !== ITER_W'(e.iters)) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d: iters=%0d need %0d, proc_ok=%b llrs_ok=%b",
                         c, out_iters, e.iters, out_proc_elem === e.proc, out_llrs === e.llrs);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || layer_prev_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b prev=%b, need 0 1 0",
                     out_valid, in_ready, layer_prev_ready);
        end
        send_frame(20, N_ITER, 1'b0, 1'b0, 1'b0);
        wait_output(N_ITER * (1 + 2), e);
        consume_output();
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        int n;
        m_lat = 3; m_early_at = 0; m_on = 1'b1;
        s0 = n_starts;
        n  = 0;
        send_frame(9, N_ITER, 1'b0, 1'b0, 1'b0);
        while (n_starts - s0 < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n_starts - s0 < 3) begin
            n_fail++;
            $display("FAIL rst_mid_reach: %0d start pulses, need 3", n_starts - s0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        n_checks++;
        if (in_ready !== 1'b1 || layer_data_ready !== 1'b0 || out_iters !== '0 || layer_all_llrs !== '0
            || out_proc_elem !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_values: in_ready=%b data=%b iters=%0d llrs_nz=%b proc_nz=%b, need 1 0 0 0 0",
                     in_ready, layer_data_ready, out_iters, |layer_all_llrs, |out_proc_elem);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || layer_prev_ready !== 1'b0 || out_iters !== '0
                || out_proc_elem !== '0) begin
                n_fail++;
                $display("FAIL rst_mid_idle_c%0d: in_ready=%b out_valid=%b prev=%b iters=%0d proc_nz=%b, need 1 0 0 0 0",
                         c, in_ready, out_valid, layer_prev_ready, out_iters, |out_proc_elem);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   s0;
        m_lat = 1; m_early_at = 0; m_on = 1'b1;
        out_ready = 1'b1;
        s0 = n_starts;
        send_frame(7, N_ITER, 1'b0, 1'b0, 1'b1);
        in_llrs = gen_llrs(8);
        wait_output(N_ITER * (1 + 1), e);
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || layer_prev_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: in_ready=%b out_valid=%b prev=%b, need 1 0 0", in_ready, out_valid, layer_prev_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (layer_prev_ready !== 1'b1 || in_ready !== 1'b0 || layer_all_llrs !== gen_llrs(8)) begin
            n_fail++;
            $display("FAIL b2b_accept: prev=%b in_ready=%b llrs_ok=%b, need 1 0 1",
                     layer_prev_ready, in_ready, layer_all_llrs === gen_llrs(8));
        end
        push_exp(8, N_ITER, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_output(N_ITER * (1 + 1), e);
        consume_output();
        n_checks++;
        if (n_starts - s0 != 2 * N_ITER) begin
            n_fail++;
            $display("FAIL b2b_start_count: %0d start pulses, need %0d", n_starts - s0, 2 * N_ITER);
        end
        n_checks++;
        if (fb_obs[s0 + N_ITER] !== '0) begin
            n_fail++;
            $display("FAIL b2b_first_feedback: edge %0d got %h need 00", first_diff(fb_obs[s0 + N_ITER], '0),
                     fb_obs[s0 + N_ITER][first_diff(fb_obs[s0 + N_ITER], '0)*WIDTH +: WIDTH]);
        end
        n_checks++;
        if (fb_obs[s0 + N_ITER + 1] !== gen_result(8, 1)) begin
            n_fail++;
            $display("FAIL b2b_second_feedback: edge %0d differs",
                     first_diff(fb_obs[s0 + N_ITER + 1], gen_result(8, 1)));
        end
    endtask

    initial begin : main
        in_valid  = 1'b0;
        in_llrs   = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        test_reset();
        test_full_iters();
        test_early_stop();
        test_timeout();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
